// File: rtl/vend_ctrl.sv
// Vending controller: shared credit accumulator, per-item prices, change paid out as 5-unit pulses.
// Define VEND_STOCK_EN to add per-item stock counters, the STOCK_INIT parameter and the sold_out_o port.
module vend_ctrl #(
  parameter int                               NUM_ITEMS   = 4,
  parameter int                               PRICE_W     = 4,
  parameter logic [NUM_ITEMS*PRICE_W-1:0]     ITEM_PRICES = {4'd6, 4'd5, 4'd4, 4'd3},
  parameter int                               MAX_CREDIT  = 8,
`ifdef VEND_STOCK_EN
  parameter int                               STOCK_INIT  = 3,
`endif
  localparam int                              SEL_W       = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               coin5_i,
  input  logic               coin10_i,
  input  logic               cancel_i,
  input  logic [SEL_W-1:0]   sel_i,
  output logic               dispense_o,
  output logic [SEL_W-1:0]   item_id_o,
  output logic               change_pulse_o,
  output logic               coin_reject_o,
  output logic [PRICE_W-1:0] credit_o,
  output logic               busy_o
`ifdef VEND_STOCK_EN
  ,
  output logic [NUM_ITEMS-1:0] sold_out_o
`endif
);

  typedef enum logic [1:0] {ACCUM, VEND, REFUND} state_e;

  localparam logic [PRICE_W:0] MAX_C = (PRICE_W+1)'(MAX_CREDIT);

  state_e               state_q, state_d;
  logic [PRICE_W-1:0]   credit_q, credit_d;
  logic [SEL_W-1:0]     item_q, item_d;
  logic                 dispense_q, change_q, reject_q, reject_d, busy_q;
  logic [PRICE_W-1:0]   sel_price, item_price;
  logic                 sel_valid, sel_sold;
  logic [NUM_ITEMS-1:0] sold;
  logic [PRICE_W:0]     sum;
  logic                 coin_any;

  // {coin10,coin5} read as a 2-bit number is exactly coin5 + 2*coin10
  assign coin_any = coin5_i | coin10_i;
  assign sum      = {1'b0, credit_q} + (PRICE_W+1)'({coin10_i, coin5_i});

  always_comb begin
    sel_price  = '0;
    item_price = '0;
    sel_valid  = 1'b0;
    sel_sold   = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel_i == SEL_W'(i)) begin
        sel_price = ITEM_PRICES[i*PRICE_W +: PRICE_W];
        sel_valid = 1'b1;
        sel_sold  = sold[i];
      end
      if (item_q == SEL_W'(i)) item_price = ITEM_PRICES[i*PRICE_W +: PRICE_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    item_d   = item_q;
    reject_d = 1'b0;
    case (state_q)
      ACCUM: begin
        if (cancel_i && credit_q != '0) begin
          reject_d = coin_any;
          state_d  = REFUND;
        end else begin
          if (sum > MAX_C) reject_d = 1'b1;
          else             credit_d = sum[PRICE_W-1:0];
          // purchase decision uses the registered credit; a coin this cycle rides along
          if (sel_valid && credit_q >= sel_price) begin
            if (sel_sold) state_d = REFUND;
            else begin
              state_d = VEND;
              item_d  = sel_i;
            end
          end
        end
      end
      VEND: begin
        reject_d = coin_any;
        credit_d = credit_q - item_price;
        state_d  = (credit_d != '0) ? REFUND : ACCUM;
      end
      REFUND: begin
        reject_d = coin_any;
        if (credit_q != '0) credit_d = credit_q - PRICE_W'(1);
        if (credit_d == '0) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ACCUM;
      credit_q   <= '0;
      item_q     <= '0;
      dispense_q <= 1'b0;
      change_q   <= 1'b0;
      reject_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      item_q     <= item_d;
      dispense_q <= (state_d == VEND);
      change_q   <= (state_d == REFUND);
      reject_q   <= reject_d;
      busy_q     <= (state_d != ACCUM);
    end
  end

`ifdef VEND_STOCK_EN
  localparam int STK_W = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;

  for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_stock
    logic [STK_W-1:0] cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= STK_W'(STOCK_INIT);
      else if (state_q == VEND && item_q == SEL_W'(g) && cnt_q != '0) cnt_q <= cnt_q - STK_W'(1);
    end
    assign sold[g] = (cnt_q == '0);
  end
  assign sold_out_o = sold;
`else
  assign sold = '0;
`endif

  assign dispense_o     = dispense_q;
  assign item_id_o      = item_q;
  assign change_pulse_o = change_q;
  assign coin_reject_o  = reject_q;
  assign credit_o       = credit_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: vector table through a scoreboard queue, plus stock and mid-refund reset sequences.
module tb_vend_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       coin5, coin10, cancel;
  logic [1:0] sel;
  logic       dispense, change_pulse, coin_reject, busy;
  logic [1:0] item_id;
  logic [3:0] credit;
`ifdef VEND_STOCK_EN
  logic [3:0] sold_out;
`endif

  always #5 clk = ~clk;

  vend_ctrl #(
    .NUM_ITEMS(4)
`ifdef VEND_STOCK_EN
    , .STOCK_INIT(1)
`endif
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .coin5_i(coin5), .coin10_i(coin10), .cancel_i(cancel),
    .sel_i(sel), .dispense_o(dispense), .item_id_o(item_id), .change_pulse_o(change_pulse),
    .coin_reject_o(coin_reject), .credit_o(credit), .busy_o(busy)
`ifdef VEND_STOCK_EN
    , .sold_out_o(sold_out)
`endif
  );

  typedef struct packed { logic d; logic [1:0] id; logic ch; logic rj; logic [3:0] cr; logic b; } out_t;
  typedef struct packed { logic rst; logic c5; logic c10; logic cx; logic [1:0] sel; out_t exp; } vec_t;

  vec_t tbl[$];
  out_t exp_q[$];
  int   n_cmp = 0, n_err = 0;

  function automatic out_t o(input bit d, input int id, input bit ch, input bit rj, input int cr, input bit b);
    out_t t;
    t.d = d; t.id = 2'(id); t.ch = ch; t.rj = rj; t.cr = 4'(cr); t.b = b;
    return t;
  endfunction

  function automatic vec_t v(input bit r, input bit c5, input bit c10, input bit cx, input int s, input out_t e);
    vec_t t;
    t.rst = r; t.c5 = c5; t.c10 = c10; t.cx = cx; t.sel = 2'(s); t.exp = e;
    return t;
  endfunction

  task automatic check(input string nm, input int idx, input out_t e);
    out_t a;
    a = {dispense, item_id, change_pulse, coin_reject, credit, busy};
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s[%0d]: got d=%0b id=%0d ch=%0b rj=%0b cr=%0d busy=%0b, want d=%0b id=%0d ch=%0b rj=%0b cr=%0d busy=%0b",
               nm, idx, a.d, a.id, a.ch, a.rj, a.cr, a.b, e.d, e.id, e.ch, e.rj, e.cr, e.b);
    end
  endtask

  task automatic step(input string nm, input int idx, input bit c5, input bit c10, input bit cx,
                      input logic [1:0] s, input out_t e);
    @(negedge clk);
    coin5 = c5; coin10 = c10; cancel = cx; sel = s;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s[%0d]: scoreboard empty", nm, idx);
    end else check(nm, idx, exp_q.pop_front());
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    coin5 = 1'b0; coin10 = 1'b0; cancel = 1'b0; rst_n = 1'b0;
    #1;
    check(nm, 0, '0);
`ifdef VEND_STOCK_EN
    n_cmp++;
    if (sold_out !== 4'b0000) begin
      n_err++;
      $display("FAIL %s sold_out: got %b want 0000", nm, sold_out);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    coin5 = 1'b0; coin10 = 1'b0; cancel = 1'b0; sel = 2'd0;
    // item 0 exact price (3 steps)
    tbl.push_back(v(1,0,1,0,0, o(0,0,0,0,2,0)));
    tbl.push_back(v(0,1,0,0,0, o(0,0,0,0,3,0)));
    tbl.push_back(v(0,0,0,0,0, o(1,0,0,0,3,1)));
    tbl.push_back(v(0,0,0,0,0, o(0,0,0,0,0,0)));
    tbl.push_back(v(0,0,0,0,0, o(0,0,0,0,0,0)));
    // item 0 overpaid by one step; coin during VEND refused
    tbl.push_back(v(1,0,1,0,0, o(0,0,0,0,2,0)));
    tbl.push_back(v(0,0,1,0,0, o(0,0,0,0,4,0)));
    tbl.push_back(v(0,0,0,0,0, o(1,0,0,0,4,1)));
    tbl.push_back(v(0,1,0,0,0, o(0,0,1,1,1,1)));
    tbl.push_back(v(0,0,0,0,0, o(0,0,0,0,0,0)));
    // item 3, both coins in one cycle
    tbl.push_back(v(1,1,1,0,3, o(0,0,0,0,3,0)));
    tbl.push_back(v(0,0,1,0,3, o(0,0,0,0,5,0)));
    tbl.push_back(v(0,1,0,0,3, o(0,0,0,0,6,0)));
    tbl.push_back(v(0,0,0,0,3, o(1,3,0,0,6,1)));
    tbl.push_back(v(0,0,0,0,3, o(0,3,0,0,0,0)));
    // credit 7 + coin10 overflows the ceiling and is refused
    tbl.push_back(v(1,0,1,0,3, o(0,0,0,0,2,0)));
    tbl.push_back(v(0,0,1,0,3, o(0,0,0,0,4,0)));
    tbl.push_back(v(0,1,0,0,3, o(0,0,0,0,5,0)));
    tbl.push_back(v(0,0,1,0,3, o(0,0,0,0,7,0)));
    tbl.push_back(v(0,0,1,0,3, o(1,3,0,1,7,1)));
    tbl.push_back(v(0,0,0,0,3, o(0,3,1,0,1,1)));
    tbl.push_back(v(0,0,0,0,3, o(0,3,0,0,0,0)));
    // credit 7 + coin5 lands exactly on the ceiling
    tbl.push_back(v(1,0,1,0,3, o(0,0,0,0,2,0)));
    tbl.push_back(v(0,0,1,0,3, o(0,0,0,0,4,0)));
    tbl.push_back(v(0,1,0,0,3, o(0,0,0,0,5,0)));
    tbl.push_back(v(0,0,1,0,3, o(0,0,0,0,7,0)));
    tbl.push_back(v(0,1,0,0,3, o(1,3,0,0,8,1)));
    tbl.push_back(v(0,0,0,0,3, o(0,3,1,0,2,1)));
    tbl.push_back(v(0,0,0,0,3, o(0,3,1,0,1,1)));
    tbl.push_back(v(0,0,0,0,3, o(0,3,0,0,0,0)));
    // cancel with coin, coin during refund, cancel at zero credit
    tbl.push_back(v(1,0,1,0,3, o(0,0,0,0,2,0)));
    tbl.push_back(v(0,1,0,0,3, o(0,0,0,0,3,0)));
    tbl.push_back(v(0,1,0,1,3, o(0,0,1,1,3,1)));
    tbl.push_back(v(0,0,1,0,3, o(0,0,1,1,2,1)));
    tbl.push_back(v(0,0,0,0,3, o(0,0,1,0,1,1)));
    tbl.push_back(v(0,0,0,0,3, o(0,0,0,0,0,0)));
    tbl.push_back(v(0,0,0,1,3, o(0,0,0,0,0,0)));
    tbl.push_back(v(0,1,0,1,3, o(0,0,0,0,1,0)));
    tbl.push_back(v(0,0,0,1,3, o(0,0,1,0,1,1)));
    tbl.push_back(v(0,0,0,0,3, o(0,0,0,0,0,0)));
    // retarget sel from 3 to 0 mid-accumulation, then item 1 at exact price
    tbl.push_back(v(1,0,1,0,3, o(0,0,0,0,2,0)));
    tbl.push_back(v(0,1,0,0,3, o(0,0,0,0,3,0)));
    tbl.push_back(v(0,0,0,0,0, o(1,0,0,0,3,1)));
    tbl.push_back(v(0,0,0,0,0, o(0,0,0,0,0,0)));
    tbl.push_back(v(0,0,1,0,1, o(0,0,0,0,2,0)));
    tbl.push_back(v(0,0,1,0,1, o(0,0,0,0,4,0)));
    tbl.push_back(v(0,0,0,0,1, o(1,1,0,0,4,1)));
    tbl.push_back(v(0,0,0,0,1, o(0,1,0,0,0,0)));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset("reset");
      step("vec", i, tbl[i].c5, tbl[i].c10, tbl[i].cx, tbl[i].sel, tbl[i].exp);
    end

`ifdef VEND_STOCK_EN
    do_reset("reset_stk");
    step("stk", 0, 0, 1, 0, 2'd0, o(0,0,0,0,2,0));
    step("stk", 1, 1, 0, 0, 2'd0, o(0,0,0,0,3,0));
    step("stk", 2, 0, 0, 0, 2'd0, o(1,0,0,0,3,1));
    step("stk", 3, 0, 0, 0, 2'd0, o(0,0,0,0,0,0));
    n_cmp++;
    if (sold_out !== 4'b0001) begin
      n_err++;
      $display("FAIL stk sold_out: got %b want 0001", sold_out);
    end
    step("stk", 4, 0, 1, 0, 2'd0, o(0,0,0,0,2,0));
    step("stk", 5, 1, 0, 0, 2'd0, o(0,0,0,0,3,0));
    step("stk", 6, 0, 0, 0, 2'd0, o(0,0,1,0,3,1));
    step("stk", 7, 0, 0, 0, 2'd0, o(0,0,1,0,2,1));
    step("stk", 8, 0, 0, 0, 2'd0, o(0,0,1,0,1,1));
    step("stk", 9, 0, 0, 0, 2'd0, o(0,0,0,0,0,0));
`endif

    // reset lands in the middle of a refund train
    do_reset("reset_mid");
    step("mid", 0, 0, 1, 0, 2'd3, o(0,0,0,0,2,0));
    step("mid", 1, 0, 1, 0, 2'd3, o(0,0,0,0,4,0));
    step("mid", 2, 0, 0, 1, 2'd3, o(0,0,1,0,4,1));
    step("mid", 3, 0, 0, 0, 2'd3, o(0,0,1,0,3,1));
    #2 rst_n = 1'b0;
    #1 check("mid_rst", 4, '0);
    @(negedge clk);
    rst_n = 1'b1;
    step("mid", 5, 0, 0, 0, 2'd3, o(0,0,0,0,0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach the end");
    $fatal(1, "timeout");
  end
endmodule
